// File: rtl/program_loader.sv
// program_loader: assembles a byte stream (MSB first, three bytes per word)
// into INSTR_W-bit instructions and writes them one at a time into the
// instruction memory, holding the CPU (busy) until the load completes.
//
// Handshake: a byte moves from source to loader on a rising edge where
// byte_valid && byte_ready are both 1. byte_valid may drop at any time
// between transfers and byte_data is ignored while byte_valid is 0.
// byte_ready is high only while a byte slot is being filled.
module program_loader #(
  parameter int INSTR_W = 19,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [4:0]         prog_len,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               write_enable,
  output logic [INSTR_W-1:0] instruction_in,
  output logic [ADDR_W-1:0]  load_addr,
  output logic               busy,
  output logic               done,
  output logic               fmt_err,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BYTE0 = 3'd1,
    BYTE1 = 3'd2,
    BYTE2 = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  // Upper two bytes of the 24-bit word being assembled (word bits 23:8).
  // The low byte goes straight into instruction_in on the third transfer.
  logic [15:0]       shadow_hi;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   len_sel;
  logic              start_ok;
  logic              xfer;
  logic              last_word;

  // Zero or over-long requests load the whole memory.
  assign len_sel   = (prog_len == 5'd0 || prog_len > 5'(DEPTH))
                   ? (ADDR_W+1)'(DEPTH) : (ADDR_W+1)'(prog_len);
  assign start_ok  = start && (state == IDLE || state == DONE);
  assign xfer      = byte_valid && byte_ready;
  assign last_word = ({1'b0, count} == len - 1'b1);
  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt    = state;
    byte_ready   = 1'b0;
    write_enable = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = BYTE0;
      BYTE0: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_nxt = BYTE1;
      end
      BYTE1: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_nxt = BYTE2;
      end
      BYTE2: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_nxt = WRITE;
      end
      WRITE: begin
        write_enable = 1'b1;
        busy         = 1'b1;
        state_nxt    = last_word ? DONE : BYTE0;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = BYTE0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load length/count, byte assembly, write word and address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len            <= '0;
      count          <= '0;
      shadow_hi      <= '0;
      instruction_in <= '0;
      load_addr      <= '0;
      fmt_err        <= 1'b0;
    end else begin
      if (start_ok) begin
        len     <= len_sel;
        count   <= '0;
        fmt_err <= 1'b0;
      end
      if (xfer) begin
        case (state)
          BYTE0: shadow_hi[15:8] <= byte_data;
          BYTE1: shadow_hi[7:0]  <= byte_data;
          BYTE2: begin
            // Word is presented during WRITE; discarded top bits flag an error.
            instruction_in <= {shadow_hi[INSTR_W-9:0], byte_data};
            load_addr      <= count;
            if (|shadow_hi[15:INSTR_W-8]) fmt_err <= 1'b1;
          end
          default: ;
        endcase
      end
      if (state == WRITE && !last_word) count <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: scenario tasks plus a write scoreboard fed by
// a word-level model of the load (bytes -> words -> expected writes).
module tb_program_loader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [4:0]  prog_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        write_enable;
  logic [18:0] instruction_in;
  logic [3:0]  load_addr;
  logic        busy;
  logic        done;
  logic        fmt_err;
  logic [2:0]  state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;
  int strobe_cnt = 0;

  // Expected writes: {addr[3:0], word[18:0]}
  logic [22:0] exp_q[$];
  logic [7:0]  stim_q[$];

  program_loader dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .prog_len       (prog_len),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .byte_ready     (byte_ready),
    .write_enable   (write_enable),
    .instruction_in (instruction_in),
    .load_addr      (load_addr),
    .busy           (busy),
    .done           (done),
    .fmt_err        (fmt_err),
    .state_dbg      (state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (reset_n && write_enable) begin
      strobe_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%0d data=%05h, expected no write", load_addr, instruction_in);
      end else begin
        logic [22:0] e;
        e = exp_q.pop_front();
        if ({load_addr, instruction_in} !== e) begin
          n_fail++;
          $display("FAIL write_data: got addr=%0d data=%05h, expected addr=%0d data=%05h",
                   load_addr, instruction_in, e[22:19], e[18:0]);
        end
      end
      n_cmp++;
      if (byte_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL ready_in_write: byte_ready=%b, expected 0", byte_ready);
      end
    end
  end

  // Driver: present one byte after 'gap' idle cycles and wait for its handshake.
  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (byte_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_cmp++;
      n_fail++;
      $display("FAIL byte_timeout: byte_ready=%b, expected 1 within 200 cycles", byte_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [4:0] plen);
    @(negedge clk);
    start    = 1'b1;
    prog_len = plen;
    @(negedge clk);
    start    = 1'b0;
    prog_len = $urandom_range(0, 31);
  endtask

  // Reference model: queue the writes for a load and return the expected
  // fmt_err; pads stim_q with random bytes up to the needed count.
  task automatic model_load(input logic [4:0] plen, output int len, output logic efmt);
    len  = (plen == 0 || plen > 16) ? 16 : int'(plen);
    efmt = 1'b0;
    while (stim_q.size() < 3 * len) stim_q.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < len; i++) begin
      int w;
      w = (int'(stim_q[3*i]) * 65536 + int'(stim_q[3*i+1]) * 256 + int'(stim_q[3*i+2])) % 524288;
      exp_q.push_back({4'(i), 19'(w)});
      if (stim_q[3*i] >= 8) efmt = 1'b1;
    end
  endtask

  // Full load with checks on start acceptance, write latency and completion.
  task automatic do_load(input string name, input logic [4:0] plen, input int gapmax);
    int   len;
    logic efmt;
    model_load(plen, len, efmt);
    strobe_cnt = 0;
    pulse_start(plen);
    n_cmp++;
    if ({busy, done, fmt_err} !== 3'b100) begin
      n_fail++;
      $display("FAIL %s_start: busy/done/fmt_err=%b, expected 100", name, {busy, done, fmt_err});
    end
    for (int i = 0; i < 3 * len; i++) send_byte(stim_q[i], $urandom_range(0, gapmax));
    stim_q.delete();
    n_cmp++;
    if (write_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_latency: write_enable=%b one cycle after last byte, expected 1", name, write_enable);
    end
    byte_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({done, busy, fmt_err} !== {2'b10, efmt}) begin
      n_fail++;
      $display("FAIL %s_done: done/busy/fmt_err=%b, expected %b", name, {done, busy, fmt_err}, {2'b10, efmt});
    end
    n_cmp++;
    if (strobe_cnt != len || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_count: strobes=%0d pending=%0d, expected %0d strobes 0 pending",
               name, strobe_cnt, exp_q.size(), len);
    end
    exp_q.delete();
  endtask

  task automatic check_quiet(input string name);
    n_cmp++;
    if ({byte_ready, write_enable, instruction_in, load_addr, busy, done, fmt_err} !== '0) begin
      n_fail++;
      $display("FAIL %s: rdy=%b we=%b instr=%05h addr=%0d busy=%b done=%b fmt=%b, expected all 0",
               name, byte_ready, write_enable, instruction_in, load_addr, busy, done, fmt_err);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; prog_len = '0; byte_valid = 1'b0; byte_data = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset_state");
    reset_n = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    repeat (4) @(negedge clk);
    check_quiet("idle_no_activity");
    byte_valid = 1'b0;
  endtask

  task automatic test_single_word();
    stim_q = '{8'h07, 8'hAB, 8'hCD};
    do_load("single", 5'd1, 0);
    n_cmp++;
    if (instruction_in !== 19'h7ABCD || load_addr !== 4'd0) begin
      n_fail++;
      $display("FAIL single_hold: instr=%05h addr=%0d, expected 7abcd addr 0", instruction_in, load_addr);
    end
  endtask

  task automatic test_full_load();
    do_load("full16", 5'd16, 0);
  endtask

  task automatic test_fmt_err();
    stim_q = '{8'hFF, 8'h12, 8'h34};
    do_load("fmt", 5'd1, 0);
    n_cmp++;
    if (instruction_in !== 19'h71234) begin
      n_fail++;
      $display("FAIL fmt_word: instr=%05h, expected 71234", instruction_in);
    end
    stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    do_load("fmt_clear", 5'd2, 0);
  endtask

  task automatic test_backpressure();
    // every byte preceded by one idle cycle
    int   len;
    logic efmt;
    model_load(5'd3, len, efmt);
    strobe_cnt = 0;
    pulse_start(5'd3);
    for (int i = 0; i < 9; i++) send_byte(stim_q[i], 1);
    stim_q.delete();
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (strobe_cnt != 3 || exp_q.size() != 0 || done !== 1'b1 || fmt_err !== efmt) begin
      n_fail++;
      $display("FAIL backpressure: strobes=%0d pending=%0d done=%b fmt=%b, expected 3 0 1 %b",
               strobe_cnt, exp_q.size(), done, fmt_err, efmt);
    end
    exp_q.delete();
    do_load("len0", 5'd0, 2);
  endtask

  task automatic test_midword_reset();
    strobe_cnt = 0;
    pulse_start(5'd2);
    send_byte(8'h03, 0);
    send_byte(8'h44, 0);
    byte_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check_quiet("midword_reset_async");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check_quiet("midword_after_reset");
    n_cmp++;
    if (strobe_cnt != 0) begin
      n_fail++;
      $display("FAIL midword_no_write: strobes=%0d, expected 0", strobe_cnt);
    end
  endtask

  task automatic test_start_while_busy();
    int   len;
    logic efmt;
    model_load(5'd3, len, efmt);
    strobe_cnt = 0;
    pulse_start(5'd3);
    send_byte(stim_q[0], 0);
    // now waiting on the second byte; a new start must not restart the load
    byte_valid = 1'b0;
    start = 1'b1;
    prog_len = 5'd1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || byte_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start_ignored: busy=%b rdy=%b, expected 1 1", busy, byte_ready);
    end
    for (int i = 1; i < 9; i++) send_byte(stim_q[i], 0);
    stim_q.delete();
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (strobe_cnt != 3 || exp_q.size() != 0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start_len: strobes=%0d pending=%0d done=%b, expected 3 0 1",
               strobe_cnt, exp_q.size(), done);
    end
    exp_q.delete();
  endtask

  task automatic test_random_loads();
    for (int k = 0; k < 6; k++) begin
      logic [4:0] p;
      p = 5'($urandom_range(0, 31));
      do_load("random", p, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_load();
    test_fmt_err();
    test_backpressure();
    test_midword_reset();
    test_start_while_busy();
    test_random_loads();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
